// File: rtl/pipe_ir_chain_if.sv
// Purpose: bundles the F-stage inputs, hazard controls and stage outputs of pipe_ir_chain.
// Latency: none; wires only.
// Backpressure: none; the hazard controls travel on this bundle to the chain.
// Ports: slave = chain side (consumes fetch/hazard inputs, drives stage words,
//        counters and error flag); master = fetch/hazard side, the mirror image.
interface pipe_ir_chain_if #(
  parameter int CNT_W = 32
) ();
  // F stage and hazard-unit controls
  logic [31:0]      instr_f;
  logic [31:0]      pc_f;
  logic             fetch_valid;
  logic             pc_en_d;
  logic             en_d;
  logic             flush_e;
  // Per-stage instruction, PC and valid
  logic [31:0]      ir_d, ir_e, ir_m, ir_w;
  logic [31:0]      pc_d, pc_e, pc_m, pc_w;
  logic             v_d, v_e, v_m, v_w;
  // Performance counters and sticky error flag
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             protocol_err;

  modport master (
    output instr_f, pc_f, fetch_valid, pc_en_d, en_d, flush_e,
    input  ir_d, ir_e, ir_m, ir_w,
    input  pc_d, pc_e, pc_m, pc_w,
    input  v_d, v_e, v_m, v_w,
    input  retire_cnt, stall_cnt, protocol_err
  );

  modport slave (
    input  instr_f, pc_f, fetch_valid, pc_en_d, en_d, flush_e,
    output ir_d, ir_e, ir_m, ir_w,
    output pc_d, pc_e, pc_m, pc_w,
    output v_d, v_e, v_m, v_w,
    output retire_cnt, stall_cnt, protocol_err
  );
endinterface

// File: rtl/pipe_ir_chain.sv
// Purpose: IR/PC/valid register chain D->E->M->W for the 5-stage MIPS core, with perf counters.
// Latency: an instruction latched into D reaches W 3 edges later; each stall edge adds one.
// Backpressure: en_d=0 holds D, flush_e=1 puts a bubble in E; M and W always advance.
// Ports: clk, rst_n (async active-low); bus (pipe_ir_chain_if.slave) carries
//        instr_f/pc_f/fetch_valid, pc_en_d/en_d/flush_e in, and ir_*/pc_*/v_*,
//        retire_cnt, stall_cnt, protocol_err out. All outputs are registered.
module pipe_ir_chain #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_ir_chain_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      ir_d, ir_e, ir_m, ir_w;
  logic [31:0]      pc_d, pc_e, pc_m, pc_w;
  logic             v_d, v_e, v_m, v_w;
  logic [CNT_W-1:0] retire_cnt, stall_cnt;
  logic             protocol_err;
  logic             ctl_legal;

  // The hazard unit only ever issues "run" (110) or "stall" (001).
  assign ctl_legal = ({bus.pc_en_d, bus.en_d, bus.flush_e} == 3'b110) ||
                     ({bus.pc_en_d, bus.en_d, bus.flush_e} == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_d         <= '0;
      ir_e         <= '0;
      ir_m         <= '0;
      ir_w         <= '0;
      pc_d         <= RESET_PC;
      pc_e         <= RESET_PC;
      pc_m         <= RESET_PC;
      pc_w         <= RESET_PC;
      v_d          <= 1'b0;
      v_e          <= 1'b0;
      v_m          <= 1'b0;
      v_w          <= 1'b0;
      retire_cnt   <= '0;
      stall_cnt    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (bus.en_d) begin
        ir_d <= bus.instr_f;
        pc_d <= bus.pc_f;
        v_d  <= bus.fetch_valid;
      end

      // A flushed E slot still carries pc_d so the bubble shows which PC stalled.
      if (bus.flush_e) begin
        ir_e <= '0;
        v_e  <= 1'b0;
      end else begin
        ir_e <= ir_d;
        v_e  <= v_d;
      end
      pc_e <= pc_d;

      ir_m <= ir_e;
      pc_m <= pc_e;
      v_m  <= v_e;
      ir_w <= ir_m;
      pc_w <= pc_m;
      v_w  <= v_m;

      if (!bus.en_d && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;

      // Retirement is the instruction leaving W; valid nops are not counted.
      if (v_w && (ir_w != 32'h0) && (retire_cnt != CNT_MAX))
        retire_cnt <= retire_cnt + CNT_ONE;

      if (!ctl_legal)
        protocol_err <= 1'b1;
    end
  end

  assign bus.ir_d         = ir_d;
  assign bus.ir_e         = ir_e;
  assign bus.ir_m         = ir_m;
  assign bus.ir_w         = ir_w;
  assign bus.pc_d         = pc_d;
  assign bus.pc_e         = pc_e;
  assign bus.pc_m         = pc_m;
  assign bus.pc_w         = pc_w;
  assign bus.v_d          = v_d;
  assign bus.v_e          = v_e;
  assign bus.v_m          = v_m;
  assign bus.v_w          = v_w;
  assign bus.retire_cnt   = retire_cnt;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.protocol_err = protocol_err;

endmodule

// File: tb/tb_pipe_ir_chain.sv
module tb_pipe_ir_chain;

  localparam int          CNT_W = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  localparam logic [31:0] I_ORI  = 32'h3401_0005;
  localparam logic [31:0] I_LW   = 32'h8c01_0000;
  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_NEXT = 32'h2463_0001;
  localparam logic [31:0] I_A    = 32'h3402_0007;
  localparam logic [31:0] I_B    = 32'h3403_0009;
  localparam logic [31:0] I_C    = 32'h3404_000b;

  localparam logic [2:0] RUN   = 3'b110;
  localparam logic [2:0] STALL = 3'b001;
  localparam logic [2:0] BAD   = 3'b100;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  pipe_ir_chain_if #(.CNT_W(CNT_W)) bus_if ();

  pipe_ir_chain #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] instr, input logic [31:0] pc,
                     input logic valid, input logic [2:0] ctl);
    bus_if.instr_f     = instr;
    bus_if.pc_f        = pc;
    bus_if.fetch_valid = valid;
    {bus_if.pc_en_d, bus_if.en_d, bus_if.flush_e} = ctl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(32'h0, 32'h0, 1'b0, RUN);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // ---- 1. reset then run ----
    rst_n = 1'b0;
    drv(32'h0, 32'h0, 1'b0, RUN);
    #1;
    chk("rst_async_ir_d", bus_if.ir_d, 32'h0);
    tick();
    tick();
    chk("rst_ir_w", bus_if.ir_w, 32'h0);
    chk("rst_pc_e", bus_if.pc_e, RPC);
    chk("rst_pc_w", bus_if.pc_w, RPC);
    chk("rst_v_m", {31'h0, bus_if.v_m}, 32'h0);
    chk("rst_retire", {28'h0, bus_if.retire_cnt}, 32'h0);
    chk("rst_stall", {28'h0, bus_if.stall_cnt}, 32'h0);
    chk("rst_err", {31'h0, bus_if.protocol_err}, 32'h0);
    rst_n = 1'b1;
    drv(I_ORI, 32'h3000, 1'b1, RUN);
    tick();
    chk("t1_ir_d", bus_if.ir_d, I_ORI);
    chk("t1_pc_d", bus_if.pc_d, 32'h3000);
    chk("t1_v_d", {31'h0, bus_if.v_d}, 32'h1);
    drv(32'h0, 32'h3004, 1'b0, RUN);
    tick();
    chk("t1_ir_e", bus_if.ir_e, I_ORI);
    tick();
    tick();
    chk("t1_ir_w", bus_if.ir_w, I_ORI);
    chk("t1_v_w", {31'h0, bus_if.v_w}, 32'h1);
    chk("t1_pc_w", bus_if.pc_w, 32'h3000);
    chk("t1_retire_pre", {28'h0, bus_if.retire_cnt}, 32'h0);
    tick();
    chk("t1_retire", {28'h0, bus_if.retire_cnt}, 32'h1);

    // ---- 2. load-use stall ----
    do_reset();
    drv(I_LW, 32'h3000, 1'b1, RUN);
    tick();
    drv(I_ADDU, 32'h3004, 1'b1, RUN);
    tick();
    chk("t2_ir_d_addu", bus_if.ir_d, I_ADDU);
    chk("t2_ir_e_lw", bus_if.ir_e, I_LW);
    drv(I_NEXT, 32'h3008, 1'b1, STALL);
    tick();
    chk("t2_ir_d_hold", bus_if.ir_d, I_ADDU);
    chk("t2_ir_e_bubble", bus_if.ir_e, 32'h0);
    chk("t2_v_e_bubble", {31'h0, bus_if.v_e}, 32'h0);
    chk("t2_pc_e_bubble", bus_if.pc_e, 32'h3004);
    chk("t2_ir_m_lw", bus_if.ir_m, I_LW);
    chk("t2_stall_cnt", {28'h0, bus_if.stall_cnt}, 32'h1);
    drv(I_NEXT, 32'h3008, 1'b1, RUN);
    tick();
    chk("t2_ir_d_next", bus_if.ir_d, I_NEXT);
    chk("t2_ir_e_addu", bus_if.ir_e, I_ADDU);
    drv(32'h0, 32'h300c, 1'b0, RUN);
    tick();
    chk("t2_ir_w_not_yet", bus_if.ir_w, 32'h0);
    chk("t2_v_w_bubble", {31'h0, bus_if.v_w}, 32'h0);
    tick();
    chk("t2_ir_w_addu", bus_if.ir_w, I_ADDU);
    chk("t2_retire_lw", {28'h0, bus_if.retire_cnt}, 32'h1);

    // ---- 3. back-to-back stalls ----
    do_reset();
    drv(I_A, 32'h3000, 1'b1, RUN);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(I_B + i, 32'h3004, 1'b1, STALL);
      tick();
      chk("t3_ir_d_hold", bus_if.ir_d, I_A);
      chk("t3_ir_e_bubble", bus_if.ir_e, 32'h0);
      chk("t3_v_e_bubble", {31'h0, bus_if.v_e}, 32'h0);
    end
    chk("t3_stall_cnt", {28'h0, bus_if.stall_cnt}, 32'h3);
    chk("t3_err", {31'h0, bus_if.protocol_err}, 32'h0);
    drv(I_B, 32'h3004, 1'b1, RUN);
    tick();
    chk("t3_ir_e_release", bus_if.ir_e, I_A);

    // ---- 4. protocol error ----
    do_reset();
    drv(I_A, 32'h3000, 1'b1, RUN);
    tick();
    drv(I_B, 32'h3004, 1'b1, RUN);
    tick();
    chk("t4_err_before", {31'h0, bus_if.protocol_err}, 32'h0);
    drv(I_C, 32'h3008, 1'b1, BAD);
    tick();
    chk("t4_err_set", {31'h0, bus_if.protocol_err}, 32'h1);
    chk("t4_ir_d_hold", bus_if.ir_d, I_B);
    chk("t4_ir_e_dup", bus_if.ir_e, I_B);
    chk("t4_ir_m", bus_if.ir_m, I_A);
    chk("t4_stall_cnt", {28'h0, bus_if.stall_cnt}, 32'h1);
    drv(I_C, 32'h3008, 1'b1, RUN);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_err_sticky", {31'h0, bus_if.protocol_err}, 32'h1);
    end
    drv(I_C, 32'h3008, 1'b1, STALL);
    tick();
    chk("t4_err_sticky_stall", {31'h0, bus_if.protocol_err}, 32'h1);
    do_reset();
    chk("t4_err_cleared", {31'h0, bus_if.protocol_err}, 32'h0);

    // ---- 5. saturation ----
    do_reset();
    drv(32'h0, 32'h0, 1'b0, STALL);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("t5_stall_14", {28'h0, bus_if.stall_cnt}, 32'd14);
      if (i == 15) chk("t5_stall_15", {28'h0, bus_if.stall_cnt}, 32'd15);
      if (i == 16) chk("t5_stall_16", {28'h0, bus_if.stall_cnt}, 32'd15);
    end
    chk("t5_stall_20", {28'h0, bus_if.stall_cnt}, 32'd15);
    for (int r = 1; r <= 24; r++) begin
      if (r <= 20) drv(32'h3400_0000 + r, 32'h3000 + 4 * r, 1'b1, RUN);
      else         drv(32'h0, 32'h0, 1'b0, RUN);
      tick();
      if (r == 5)  chk("t5_retire_5", {28'h0, bus_if.retire_cnt}, 32'd1);
      if (r == 18) chk("t5_retire_18", {28'h0, bus_if.retire_cnt}, 32'd14);
      if (r == 19) chk("t5_retire_19", {28'h0, bus_if.retire_cnt}, 32'd15);
      if (r == 20) chk("t5_retire_20", {28'h0, bus_if.retire_cnt}, 32'd15);
    end
    chk("t5_retire_24", {28'h0, bus_if.retire_cnt}, 32'd15);
    chk("t5_stall_after", {28'h0, bus_if.stall_cnt}, 32'd15);

    // ---- 6. mid-operation asynchronous reset ----
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      drv(32'h3400_0010 + r, 32'h3000 + 4 * r, 1'b1, RUN);
      tick();
    end
    chk("t6_full_ir_w", bus_if.ir_w, 32'h3400_0012);
    chk("t6_full_v_w", {31'h0, bus_if.v_w}, 32'h1);
    chk("t6_full_retire", {28'h0, bus_if.retire_cnt}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ir_w", bus_if.ir_w, 32'h0);
    chk("t6_async_ir_d", bus_if.ir_d, 32'h0);
    chk("t6_async_v_w", {31'h0, bus_if.v_w}, 32'h0);
    chk("t6_async_v_d", {31'h0, bus_if.v_d}, 32'h0);
    chk("t6_async_pc_w", bus_if.pc_w, RPC);
    chk("t6_async_pc_d", bus_if.pc_d, RPC);
    chk("t6_async_retire", {28'h0, bus_if.retire_cnt}, 32'h0);
    drv(32'h0, 32'h0, 1'b0, RUN);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_idle_retire", {28'h0, bus_if.retire_cnt}, 32'h0);
    end
    drv(I_ORI, 32'h3000, 1'b1, RUN);
    tick();
    chk("t6_new_ir_d", bus_if.ir_d, I_ORI);
    drv(32'h0, 32'h3004, 1'b0, RUN);
    tick();
    tick();
    tick();
    chk("t6_new_ir_w", bus_if.ir_w, I_ORI);
    chk("t6_new_retire_pre", {28'h0, bus_if.retire_cnt}, 32'h0);
    tick();
    chk("t6_new_retire", {28'h0, bus_if.retire_cnt}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
